multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the RV64I datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,

---
 rtl/multicycle_control.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I datapath with shared-memory handshake.
// Optional PERF_CNT_EN adds free-running cycle_count / instret_count outputs.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  OpCode,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_ifetch,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
`ifdef PERF_CNT_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_SAT = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_r;
  state_t          state_nxt_s;
  logic [TO_W-1:0] wcnt_r;
  logic [1:0]      cause_r;
  logic [1:0]      cause_nxt_s;
  logic            timeout_s;

  assign timeout_s  = (MEM_TIMEOUT != 0) && (wcnt_r == TO_MAX) && !mem_ready;
  assign state      = state_r;
  assign trap_cause = cause_r;

  // Next-state and strobe decode; everything stays low while reset is held.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = 2'b00;
    mem_req     = 1'b0;
    mem_ifetch  = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 1'b0;
    ALUSrc      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Branch      = 1'b0;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    trap        = 1'b0;
    if (!reset) begin
      case (state_r)
        S_FETCH: begin
          mem_req    = 1'b1;
          mem_ifetch = 1'b1;
          MemRead    = 1'b1;
          if (mem_ready) begin
            IRWrite     = 1'b1;
            state_nxt_s = S_DECODE;
          end else if (timeout_s) begin
            state_nxt_s = S_TRAP;
            cause_nxt_s = CAUSE_TIMEOUT;
          end else begin
            state_nxt_s = S_FETCH;
          end
        end
        S_DECODE: begin
          case (OpCode)
            OP_R, OP_I, OP_LD, OP_ST, OP_BR: state_nxt_s = S_EXEC;
            default: begin
              state_nxt_s = S_TRAP;
              cause_nxt_s = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_EXEC: begin
          case (OpCode)
            OP_R: begin
              ALUOp       = 2'b10;
              state_nxt_s = S_WB;
            end
            OP_I: begin
              ALUSrc      = 1'b1;
              ALUOp       = 2'b10;
              state_nxt_s = S_WB;
            end
            OP_LD, OP_ST: begin
              ALUSrc      = 1'b1;
              ALUOp       = 2'b00;
              state_nxt_s = S_MEM;
            end
            OP_BR: begin
              ALUOp       = 2'b01;
              Branch      = 1'b1;
              PCWrite     = 1'b1;
              PCSrc       = Zero;
              instr_done  = 1'b1;
              state_nxt_s = S_FETCH;
            end
            default: begin
              state_nxt_s = S_TRAP;
              cause_nxt_s = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEM: begin
          case (OpCode)
            OP_LD: begin
              mem_req = 1'b1;
              MemRead = 1'b1;
              if (mem_ready) begin
                state_nxt_s = S_WB;
              end else if (timeout_s) begin
                state_nxt_s = S_TRAP;
                cause_nxt_s = CAUSE_TIMEOUT;
              end else begin
                state_nxt_s = S_MEM;
              end
            end
            OP_ST: begin
              mem_req  = 1'b1;
              MemWrite = 1'b1;
              if (mem_ready) begin
                PCWrite     = 1'b1;
                instr_done  = 1'b1;
                state_nxt_s = S_FETCH;
              end else if (timeout_s) begin
                state_nxt_s = S_TRAP;
                cause_nxt_s = CAUSE_TIMEOUT;
              end else begin
                state_nxt_s = S_MEM;
              end
            end
            default: begin
              state_nxt_s = S_TRAP;
              cause_nxt_s = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_WB: begin
          RegWrite    = 1'b1;
          MemtoReg    = (OpCode == OP_LD);
          PCWrite     = 1'b1;
          instr_done  = 1'b1;
          state_nxt_s = S_FETCH;
        end
        S_TRAP: begin
          trap        = 1'b1;
          state_nxt_s = S_TRAP;
        end
        default: begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = CAUSE_ILLEGAL;
        end
      endcase
    end else begin
      state_nxt_s = S_FETCH;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Trap cause captured only on the transition into TRAP, so it can never be overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_r <= 2'b00;
    end else if ((state_r != S_TRAP) && (state_nxt_s == S_TRAP)) begin
      cause_r <= cause_nxt_s;
    end else begin
      cause_r <= cause_r;
    end
  end

  // Memory wait counter: cleared on entry to FETCH/MEM, saturating count of stalled request cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_r <= {TO_W{1'b0}};
    end else if ((state_nxt_s != state_r) &&
                 ((state_nxt_s == S_FETCH) || (state_nxt_s == S_MEM))) begin
      wcnt_r <= {TO_W{1'b0}};
    end else if (mem_req && !mem_ready && (wcnt_r != TO_SAT)) begin
      wcnt_r <= wcnt_r + TO_ONE;
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

`ifdef PERF_CNT_EN
  // Performance counters, frozen once the core has trapped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= 64'd0;
      instret_count <= 64'd0;
    end else if (!trap) begin
      cycle_count   <= cycle_count + 64'd1;
      instret_count <= instret_count + {63'd0, instr_done};
    end else begin
      cycle_count   <= cycle_count;
      instret_count <= instret_count;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: per-cycle stimulus and expected outputs are queued,
// then replayed and compared at the falling edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  OpCode = 7'd0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_ifetch, IRWrite, PCWrite, PCSrc, ALUSrc, MemtoReg;
  logic        RegWrite, MemRead, MemWrite, Branch, instr_done, trap;
  logic [1:0]  ALUOp, trap_cause;
  logic [2:0]  state;
`ifdef PERF_CNT_EN
  logic [63:0] cycle_count, instret_count;
`endif

  multicycle_control #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_ifetch(mem_ifetch), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause), .state(state)
`ifdef PERF_CNT_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // strobe bits: {req, ifetch, IRWrite, PCWrite, PCSrc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch}
  localparam logic [10:0] NONE = 11'h000;
  localparam logic [10:0] REQ  = 11'h400;
  localparam logic [10:0] IFET = 11'h200;
  localparam logic [10:0] IRW  = 11'h100;
  localparam logic [10:0] PCW  = 11'h080;
  localparam logic [10:0] PCS  = 11'h040;
  localparam logic [10:0] ALUS = 11'h020;
  localparam logic [10:0] M2R  = 11'h010;
  localparam logic [10:0] RW   = 11'h008;
  localparam logic [10:0] MR   = 11'h004;
  localparam logic [10:0] MW   = 11'h002;
  localparam logic [10:0] BR   = 11'h001;

  typedef struct packed {
    logic [2:0]  st;
    logic [10:0] strb;
    logic [1:0]  aluop;
    logic        done;
    logic        trp;
    logic [1:0]  cause;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic       z;
    logic       rdy;
  } stim_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t mk(input logic [2:0] st, input logic [10:0] strb, input logic [1:0] aluop,
                              input logic done, input logic trp, input logic [1:0] cause);
    obs_t o;
    o.st = st; o.strb = strb; o.aluop = aluop; o.done = done; o.trp = trp; o.cause = cause;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st    = state;
    o.strb  = {mem_req, mem_ifetch, IRWrite, PCWrite, PCSrc, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, Branch};
    o.aluop = ALUOp;
    o.done  = instr_done;
    o.trp   = trap;
    o.cause = trap_cause;
    return o;
  endfunction

  task automatic push(input string tag, input logic rst, input logic [6:0] op, input logic z,
                      input logic rdy, input obs_t e);
    stim_t s;
    s.rst = rst; s.op = op; s.z = z; s.rdy = rdy;
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run();
    stim_t s;
    obs_t  e, o;
    string t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; OpCode = s.op; Zero = s.z; mem_ready = s.rdy;
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = sample();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic p_reset(input string tag, input int n);
    for (int i = 0; i < n; i++) push(tag, 1'b1, OP_ST, 1'b1, 1'b1, mk(3'd0, NONE, 2'b00, 1'b0, 1'b0, 2'b00));
  endtask

  task automatic p_fetch(input string tag, input logic [6:0] op, input logic z, input int waits);
    for (int i = 0; i < waits; i++) push(tag, 1'b0, op, z, 1'b0, mk(3'd0, REQ | IFET | MR, 2'b00, 1'b0, 1'b0, 2'b00));
    push(tag, 1'b0, op, z, 1'b1, mk(3'd0, REQ | IFET | MR | IRW, 2'b00, 1'b0, 1'b0, 2'b00));
    push(tag, 1'b0, op, z, 1'b0, mk(3'd1, NONE, 2'b00, 1'b0, 1'b0, 2'b00));
  endtask

  task automatic p_alu(input string tag, input logic [6:0] op, input int fw);
    p_fetch(tag, op, 1'b1, fw);
    push(tag, 1'b0, op, 1'b1, 1'b1, mk(3'd2, (op == OP_I) ? ALUS : NONE, 2'b10, 1'b0, 1'b0, 2'b00));
    push(tag, 1'b0, op, 1'b1, 1'b1, mk(3'd4, RW | PCW, 2'b00, 1'b1, 1'b0, 2'b00));
  endtask

  task automatic p_ld(input string tag, input int fw, input int mw);
    p_fetch(tag, OP_LD, 1'b0, fw);
    push(tag, 1'b0, OP_LD, 1'b0, 1'b0, mk(3'd2, ALUS, 2'b00, 1'b0, 1'b0, 2'b00));
    for (int i = 0; i < mw; i++) push(tag, 1'b0, OP_LD, 1'b0, 1'b0, mk(3'd3, REQ | MR, 2'b00, 1'b0, 1'b0, 2'b00));
    push(tag, 1'b0, OP_LD, 1'b0, 1'b1, mk(3'd3, REQ | MR, 2'b00, 1'b0, 1'b0, 2'b00));
    push(tag, 1'b0, OP_LD, 1'b0, 1'b0, mk(3'd4, RW | M2R | PCW, 2'b00, 1'b1, 1'b0, 2'b00));
  endtask

  task automatic p_st(input string tag, input int mw);
    p_fetch(tag, OP_ST, 1'b0, 0);
    push(tag, 1'b0, OP_ST, 1'b0, 1'b0, mk(3'd2, ALUS, 2'b00, 1'b0, 1'b0, 2'b00));
    for (int i = 0; i < mw; i++) push(tag, 1'b0, OP_ST, 1'b0, 1'b0, mk(3'd3, REQ | MW, 2'b00, 1'b0, 1'b0, 2'b00));
    push(tag, 1'b0, OP_ST, 1'b0, 1'b1, mk(3'd3, REQ | MW | PCW, 2'b00, 1'b1, 1'b0, 2'b00));
  endtask

  task automatic p_br(input string tag, input logic z);
    p_fetch(tag, OP_BR, z, 0);
    push(tag, 1'b0, OP_BR, z, 1'b1, mk(3'd2, BR | PCW | (z ? PCS : NONE), 2'b01, 1'b1, 1'b0, 2'b00));
  endtask

  task automatic p_trap(input string tag, input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++) push(tag, 1'b0, OP_R, 1'b1, 1'b1, mk(3'd7, NONE, 2'b00, 1'b0, 1'b1, cause));
  endtask

  initial begin
    @(posedge clk);
    #1;
    p_reset("reset", 2);
    run();
`ifdef PERF_CNT_EN
    check64("perf_cycle_reset", cycle_count, 64'd0);
    check64("perf_instret_reset", instret_count, 64'd0);
`endif

    p_alu("rtype", OP_R, 0);
    p_alu("itype", OP_I, 0);
    p_ld("ld_wait3", 0, 3);
    p_ld("ld_fw3_mw3", 3, 3);
    p_st("st", 0);
    p_st("st_wait2", 2);
    p_br("br_z1", 1'b1);
    p_br("br_z0", 1'b0);
    run();

    // illegal opcode traps out of DECODE and stays there
    p_fetch("illegal", OP_BAD, 1'b0, 0);
    p_trap("illegal_hold", 100, 2'b01);
    p_reset("illegal_reset", 1);
    p_alu("after_reset", OP_R, 0);
    run();

    // fetch timeout at the fifth stalled request cycle
    for (int i = 0; i < 5; i++) push("fetch_to", 1'b0, OP_R, 1'b0, 1'b0, mk(3'd0, REQ | IFET | MR, 2'b00, 1'b0, 1'b0, 2'b00));
    p_trap("fetch_to_trap", 3, 2'b10);
    p_reset("fetch_to_reset", 1);
    p_alu("fetch_ready_on_expiry", OP_R, 4);
    run();

    // load data-phase timeout
    p_fetch("mem_to", OP_LD, 1'b0, 0);
    push("mem_to", 1'b0, OP_LD, 1'b0, 1'b0, mk(3'd2, ALUS, 2'b00, 1'b0, 1'b0, 2'b00));
    for (int i = 0; i < 5; i++) push("mem_to", 1'b0, OP_LD, 1'b0, 1'b0, mk(3'd3, REQ | MR, 2'b00, 1'b0, 1'b0, 2'b00));
    p_trap("mem_to_trap", 2, 2'b10);
    p_reset("mem_to_reset", 1);
    run();

    // reset mid-MEM of a store
    p_fetch("st_abort", OP_ST, 1'b0, 0);
    push("st_abort", 1'b0, OP_ST, 1'b0, 1'b0, mk(3'd2, ALUS, 2'b00, 1'b0, 1'b0, 2'b00));
    push("st_abort", 1'b0, OP_ST, 1'b0, 1'b0, mk(3'd3, REQ | MW, 2'b00, 1'b0, 1'b0, 2'b00));
    p_reset("st_abort_reset", 2);
    run();
`ifdef PERF_CNT_EN
    check64("perf_cycle_zero", cycle_count, 64'd0);
    check64("perf_instret_zero", instret_count, 64'd0);
`endif
    p_alu("perf_r1", OP_R, 0);
    p_alu("perf_r2", OP_R, 0);
    p_alu("perf_r3", OP_R, 0);
    run();
`ifdef PERF_CNT_EN
    check64("perf_instret_3", instret_count, 64'd3);
    check64("perf_cycle_12", cycle_count, 64'd12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
